reversible_counter: RTL and testbench

Up/down (reversible) binary counter that accumulates position from the count-enable and direction strobes produced by the incremental-encoder quadrature decoder. It sits between the decoder and the register/bus interface of the encoder controller. It provides optional input synchronisation, modulo or saturating arithmetic, and a parameterisable width.

---
 rtl/reversible_counter.sv | 70 +++++++
 tb/tb_reversible_counter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reversible_counter.sv
// Up/down position counter fed by the quadrature decoder's count-enable and
// direction strobes. It has optional input synchronisers and either wrapping or clamping arithmetic.
module reversible_counter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int SATURATE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic en_s;
    logic dir_s;
    logic at_max;
    logic at_min;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign en_s  = enable;
            assign dir_s = dir;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] en_sync;
            logic [SYNC_STAGES-1:0] dir_sync;

            // Chains reset to zero so that no count is produced while they refill after reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    en_sync  <= '0;
                    dir_sync <= '0;
                end else begin
                    en_sync[0]  <= enable;
                    dir_sync[0] <= dir;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        en_sync[i]  <= en_sync[i-1];
                        dir_sync[i] <= dir_sync[i-1];
                    end
                end
            end

            assign en_s  = en_sync[SYNC_STAGES-1];
            assign dir_s = dir_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign at_max = (cnt == {WIDTH{1'b1}});
    assign at_min = (cnt == {WIDTH{1'b0}});

    // A step is suppressed only when saturating and already at the limit in the counting direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en_s) begin
            if (dir_s) begin
                if (!((SATURATE != 0) && at_max)) begin
                    cnt <= cnt + ONE;
                end
            end else begin
                if (!((SATURATE != 0) && at_min)) begin
                    cnt <= cnt - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_reversible_counter.sv
// Self-checking bench for reversible_counter. It runs a wrapping instance, a saturating instance and a
// small unsynchronised saturating instance from the same stimulus, using scoreboard queues per instance.
module tb_reversible_counter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        dir;
    logic [31:0] cnt;
    logic [31:0] cnt_sat;
    logic [3:0]  cnt_small;

    int checks;
    int passes;
    bit armed;

    logic [31:0] exp_main;
    logic [31:0] exp_sat;
    logic [31:0] exp_small;
    logic [31:0] q_main[$];
    logic [31:0] q_sat[$];
    logic [31:0] q_small[$];

    reversible_counter #(.WIDTH(32), .SYNC_STAGES(2), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .cnt(cnt)
    );

    reversible_counter #(.WIDTH(32), .SYNC_STAGES(2), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .cnt(cnt_sat)
    );

    reversible_counter #(.WIDTH(4), .SYNC_STAGES(0), .SATURATE(1)) dut_small (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .cnt(cnt_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_next(input logic [31:0] c, input logic en, input logic d,
                                                input int w, input bit sat);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        if (!en) return c;
        if (d) return (sat && c == mask) ? c : ((c + 32'd1) & mask);
        return (sat && c == 32'd0) ? c : ((c - 32'd1) & mask);
    endfunction

    // Scoreboard: expectations are pushed at the edge that captures the stimulus and
    // popped once the instance's latency has elapsed.
    always @(posedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            q_main.delete();
            q_sat.delete();
            q_small.delete();
            exp_main  = 32'd0;
            exp_sat   = 32'd0;
            exp_small = 32'd0;
        end else if (armed) begin
            exp_main  = model_next(exp_main, enable, dir, 32, 1'b0);
            exp_sat   = model_next(exp_sat, enable, dir, 32, 1'b1);
            exp_small = model_next(exp_small, enable, dir, 4, 1'b1);
            q_main.push_back(exp_main);
            q_sat.push_back(exp_sat);
            q_small.push_back(exp_small);
        end
        #1;
        if (armed && rst) begin
            if (q_main.size() > 2) begin
                e = q_main.pop_front();
                checks++;
                if (cnt !== e) $display("[TB] FAIL sb_main: cnt=%h expected=%h", cnt, e);
                else passes++;
            end
            if (q_sat.size() > 2) begin
                e = q_sat.pop_front();
                checks++;
                if (cnt_sat !== e) $display("[TB] FAIL sb_sat: cnt=%h expected=%h", cnt_sat, e);
                else passes++;
            end
            if (q_small.size() > 0) begin
                e = q_small.pop_front();
                checks++;
                if (cnt_small !== e[3:0]) $display("[TB] FAIL sb_small: cnt=%h expected=%h", cnt_small, e[3:0]);
                else passes++;
            end
        end
    end

    task automatic run_edges(input logic en, input logic d, input int n);
        @(negedge clk);
        enable = en;
        dir    = d;
        repeat (n) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        dir    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL reset_async: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
        checks++;
        if (cnt_small !== 4'd0) $display("[TB] FAIL reset_async_small: cnt=%h expected=%h", cnt_small, 4'd0);
        else passes++;
        armed = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL reset_hold: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
    endtask

    task automatic test_dir_toggle();
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dir = ~dir;
            repeat (10) @(negedge clk);
        end
        #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL dir_toggle: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
    endtask

    task automatic test_down_wrap();
        @(negedge clk);
        enable = 1'b1;
        dir    = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL down_lat_edge0: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL down_lat_edge1: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (cnt !== 32'hFFFF_FFFF) $display("[TB] FAIL down_lat_edge2: cnt=%h expected=%h", cnt, 32'hFFFF_FFFF);
        else passes++;
        repeat (7) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cnt !== 32'hFFFF_FFF7) $display("[TB] FAIL down_tail1: cnt=%h expected=%h", cnt, 32'hFFFF_FFF7);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (cnt !== 32'hFFFF_FFF6) $display("[TB] FAIL down_final: cnt=%h expected=%h", cnt, 32'hFFFF_FFF6);
        else passes++;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (cnt !== 32'hFFFF_FFF6) $display("[TB] FAIL down_stable: cnt=%h expected=%h", cnt, 32'hFFFF_FFF6);
        else passes++;
        checks++;
        if (cnt_sat !== 32'd0) $display("[TB] FAIL down_sat_floor: cnt=%h expected=%h", cnt_sat, 32'd0);
        else passes++;
    endtask

    task automatic test_up_to_zero();
        run_edges(1'b1, 1'b1, 10);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL up_to_zero: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
        checks++;
        if (cnt_sat !== 32'd10) $display("[TB] FAIL up_sat: cnt=%h expected=%h", cnt_sat, 32'd10);
        else passes++;
        run_edges(1'b1, 1'b0, 10);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cnt !== 32'hFFFF_FFF6) $display("[TB] FAIL back_down: cnt=%h expected=%h", cnt, 32'hFFFF_FFF6);
        else passes++;
    endtask

    task automatic test_saturation();
        pulse_reset();
        run_edges(1'b1, 1'b0, 5);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cnt_sat !== 32'd0) $display("[TB] FAIL sat_floor: cnt=%h expected=%h", cnt_sat, 32'd0);
        else passes++;
        run_edges(1'b1, 1'b1, 3);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cnt_sat !== 32'd3) $display("[TB] FAIL sat_up3: cnt=%h expected=%h", cnt_sat, 32'd3);
        else passes++;
        run_edges(1'b1, 1'b1, 20);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (cnt_small !== 4'hF) $display("[TB] FAIL sat_ceiling_small: cnt=%h expected=%h", cnt_small, 4'hF);
        else passes++;
        checks++;
        if (cnt_sat !== 32'd23) $display("[TB] FAIL sat_up23: cnt=%h expected=%h", cnt_sat, 32'd23);
        else passes++;
    endtask

    task automatic test_reset_midcount();
        int budget;
        pulse_reset();
        @(negedge clk);
        enable = 1'b1;
        dir    = 1'b1;
        budget = 0;
        do begin
            @(posedge clk); #1;
            budget++;
        end while (cnt !== 32'd7 && budget < 30);
        checks++;
        if (cnt !== 32'd7) $display("[TB] FAIL mid_reach7: cnt=%h expected=%h", cnt, 32'd7);
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL mid_async_clear: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (cnt !== 32'd0) $display("[TB] FAIL mid_refill: cnt=%h expected=%h", cnt, 32'd0);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (cnt !== 32'd1) $display("[TB] FAIL mid_resume1: cnt=%h expected=%h", cnt, 32'd1);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (cnt !== 32'd2) $display("[TB] FAIL mid_resume2: cnt=%h expected=%h", cnt, 32'd2);
        else passes++;
        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        armed  = 1'b0;
        exp_main  = 32'd0;
        exp_sat   = 32'd0;
        exp_small = 32'd0;
        test_reset();
        test_dir_toggle();
        test_down_wrap();
        test_up_to_zero();
        test_saturation();
        test_reset_midcount();
        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
